msg_link_tx: RTL and testbench

Transmit side of the A/B message link. Buffers 32-bit messages from the local producer and drives them onto the link as a one-cycle `send` strobe with a stable `message` word. It waits for the receiving machine's `ack`, retransmits on timeout, and drops a message after bounded retries. It sits directly upstream of the receiving machine's message-receive stage, which consumes `send` and `message`.

---
 rtl/msg_link_pkg.sv | 18 +
 rtl/msg_link_tx_if.sv | 28 ++
 rtl/msg_fifo.sv | 77 +++++++
 rtl/msg_link_tx.sv | 139 +++++++++++++
 tb/tb_msg_link_tx.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_link_pkg.sv
// Shared types and constants for the A/B message link transmit side.
package msg_link_pkg;

    localparam int unsigned MSG_W = 32;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } tx_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/msg_link_tx_if.sv
// Producer handshake, link strobe/ack and status bundle of msg_link_tx.
interface msg_link_tx_if;
    import msg_link_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [MSG_W-1:0] in_msg;
    logic             send;
    logic [MSG_W-1:0] message;
    logic             ack;
    logic             busy;
    logic             drop_err;
    logic [CNT_W-1:0] sent_count;
    logic [CNT_W-1:0] drop_count;

    // Environment side: local producer plus the receiving machine.
    modport master (
        output in_valid, in_msg, ack,
        input  in_ready, send, message, busy, drop_err, sent_count, drop_count
    );

    // Transmitter side.
    modport slave (
        input  in_valid, in_msg, ack,
        output in_ready, send, message, busy, drop_err, sent_count, drop_count
    );

endinterface

// File: rtl/msg_fifo.sv
// Small synchronous FIFO holding messages waiting for transmission.
// Pointers wrap modulo DEPTH; the occupancy counter separates full from empty.
module msg_fifo
    import msg_link_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [MSG_W-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [MSG_W-1:0]             head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int unsigned PtrW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);

    logic [MSG_W-1:0] mem_q [DEPTH];
    logic [MSG_W-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o      = (count_q == CntW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign occupancy_o = count_q;
    assign head_o      = mem_q[rd_ptr_q];

    // Refuse writes when full and reads when empty so the pointers never lap.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/msg_link_tx.sv
// Transmit side of the A/B message link: queues producer words, strobes them
// onto the link, waits for ack, retransmits on timeout and drops after
// MAX_RETRY retransmissions.
module msg_link_tx
    import msg_link_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TIMEOUT   = 8,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic          clk,
    input  logic          reset,
    msg_link_tx_if.slave  bus
);

    localparam int unsigned TimerW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned OccW   = $clog2(DEPTH + 1);

    tx_state_t        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic             send_q, send_d;
    logic [MSG_W-1:0] message_q, message_d;
    logic             drop_err_q, drop_err_d;
    logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic [MSG_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OccW-1:0]  fifo_occ;
    logic             timer_expired;

    assign fifo_push = bus.in_valid && !fifo_full;

    msg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (bus.in_msg),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .occupancy_o (fifo_occ)
    );

    assign timer_expired = (timer_q == TimerW'(TIMEOUT - 1));

    // Next-state, transmit strobe, pop request and counter updates.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        message_d  = message_q;
        send_d     = 1'b0;
        drop_err_d = 1'b0;
        sent_cnt_d = sent_cnt_q;
        drop_cnt_d = drop_cnt_q;
        fifo_pop   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = SEND;
                    message_d = fifo_head;
                    send_d    = 1'b1;
                end
            end
            SEND: begin
                state_d = WAIT_ACK;
                timer_d = '0;
            end
            WAIT_ACK: begin
                timer_d = timer_q + TimerW'(1);
                // ack outranks the timeout decision on the same cycle
                if (bus.ack) begin
                    fifo_pop   = 1'b1;
                    sent_cnt_d = sat_inc(sent_cnt_q);
                    retry_d    = '0;
                    state_d    = IDLE;
                end else if (timer_expired) begin
                    if (retry_q < RetryW'(MAX_RETRY)) begin
                        // message_q still holds the head word, resend it unchanged
                        retry_d = retry_q + RetryW'(1);
                        state_d = SEND;
                        send_d  = 1'b1;
                    end else begin
                        fifo_pop   = 1'b1;
                        drop_cnt_d = sat_inc(drop_cnt_q);
                        drop_err_d = 1'b1;
                        retry_d    = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, timer, retry and registered outputs; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            retry_q    <= '0;
            send_q     <= 1'b0;
            message_q  <= '0;
            drop_err_q <= 1'b0;
            sent_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            send_q     <= send_d;
            message_q  <= message_d;
            drop_err_q <= drop_err_d;
            sent_cnt_q <= sent_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.busy       = (state_q != IDLE) || (fifo_occ != '0);
    assign bus.send       = send_q;
    assign bus.message    = message_q;
    assign bus.drop_err   = drop_err_q;
    assign bus.sent_count = sent_cnt_q;
    assign bus.drop_count = drop_cnt_q;

endmodule

// File: tb/tb_msg_link_tx.sv
// Scoreboard bench for msg_link_tx: each pushed word carries an ack plan
// (which attempt gets acked, on which WAIT_ACK cycle, or never). A responder
// plays the receiver from the plan; a monitor checks every send, ack and drop.
module tb_msg_link_tx;
    import msg_link_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned TIMEOUT   = 8;
    localparam int unsigned MAX_RETRY = 3;

    typedef struct {
        logic [MSG_W-1:0] msg;
        int unsigned      ack_attempt;  // 0: never acked; n: acked on n-th send
        int unsigned      delay;        // WAIT_ACK cycle index carrying the ack
        bit               send_ack;     // also raise ack during SEND (must be ignored)
    } plan_t;

    logic clk = 1'b0;
    logic reset;

    msg_link_tx_if bus();

    msg_link_tx #(
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    plan_t       exp_q[$];
    plan_t       plan_q[$];
    int unsigned tot_sent = 0;
    int unsigned tot_drop = 0;
    bit          idle_ack_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic plan_t mk(input int unsigned att, input int unsigned dly, input bit sa);
        plan_t p;
        p.msg         = '0;
        p.ack_attempt = att;
        p.delay       = dly;
        p.send_ack    = sa;
        return p;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [MSG_W-1:0] m, input plan_t p);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_msg   = m;
        while (!bus.in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("push_accepted_in_time", guard < 2000, 1);
        p.msg = m;
        exp_q.push_back(p);
        plan_q.push_back(p);
        if (p.ack_attempt != 0) tot_sent++;
        else tot_drop++;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || bus.busy) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_drained"}, guard < 2000, 1);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_send"},       bus.send,       0);
        chk({name, "_message"},    bus.message,    0);
        chk({name, "_drop_err"},   bus.drop_err,   0);
        chk({name, "_sent_count"}, bus.sent_count, 0);
        chk({name, "_drop_count"}, bus.drop_count, 0);
        chk({name, "_busy"},       bus.busy,       0);
        chk({name, "_in_ready"},   bus.in_ready,   1);
    endtask

    // Receiver model: acks according to the plan of the word at the queue head.
    initial begin
        plan_t       cur;
        int          rk;
        int unsigned ratt;
        bit          acking;
        bus.ack = 1'b0;
        rk      = -1;
        ratt    = 0;
        cur     = mk(0, 0, 1'b0);
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.ack = 1'b0;
                rk      = -1;
                ratt    = 0;
            end else if (bus.send) begin
                if (ratt == 0) cur = (plan_q.size() > 0) ? plan_q[0] : mk(0, 0, 1'b0);
                ratt++;
                rk      = 0;
                bus.ack = cur.send_ack;
            end else if (rk >= 0) begin
                rk++;
                acking  = (cur.ack_attempt == ratt) && (rk == int'(cur.delay) + 1);
                bus.ack = acking;
                if (acking) begin
                    if (plan_q.size() > 0) void'(plan_q.pop_front());
                    ratt = 0;
                    rk   = -1;
                end else if (rk == int'(TIMEOUT)) begin
                    rk = -1;
                    if (ratt == MAX_RETRY + 1) begin
                        if (plan_q.size() > 0) void'(plan_q.pop_front());
                        ratt = 0;
                    end
                end
            end else begin
                // link is idle here, so a stray ack must have no effect
                bus.ack = idle_ack_en && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: compares every observed send / ack / drop with the queue head.
    int unsigned      cyc = 0;
    int unsigned      last_send_cyc = 0;
    int unsigned      cur_sends = 0;
    int unsigned      model_sent = 0;
    int unsigned      model_drop = 0;
    logic [CNT_W-1:0] prev_sent = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            cur_sends  = 0;
            prev_sent  = '0;
            model_sent = 0;
            model_drop = 0;
        end else begin
            if (bus.send) begin
                chk("pending_at_send", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("send_message", bus.message, exp_q[0].msg);
                    if (cur_sends > 0) chk("retry_spacing", cyc - last_send_cyc, TIMEOUT + 1);
                    cur_sends++;
                    last_send_cyc = cyc;
                end
            end
            if (bus.sent_count != prev_sent) begin
                prev_sent = bus.sent_count;
                chk("pending_at_ack", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    model_sent++;
                    chk("acked_on_attempt", cur_sends, exp_q[0].ack_attempt);
                    chk("sent_count_step", bus.sent_count, model_sent);
                    void'(exp_q.pop_front());
                    cur_sends = 0;
                end
            end
            if (bus.drop_err) begin
                chk("pending_at_drop", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    model_drop++;
                    chk("drop_expected", exp_q[0].ack_attempt, 0);
                    chk("sends_before_drop", cur_sends, MAX_RETRY + 1);
                    chk("drop_count_step", bus.drop_count, model_drop);
                    void'(exp_q.pop_front());
                    cur_sends = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got no finish, required finish before %0t", $time);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_msg   = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Single message with latency profile.
        push(32'd42, mk(1, 0, 1'b0));
        chk("single_no_send_yet", bus.send, 0);
        chk("single_busy_queued", bus.busy, 1);
        @(negedge clk);
        chk("single_send_pulse", bus.send, 1);
        chk("single_message", bus.message, 42);
        @(negedge clk);
        chk("single_send_one_cycle", bus.send, 0);
        @(negedge clk);
        chk("single_busy_done", bus.busy, 0);
        chk("single_sent_count", bus.sent_count, 1);
        chk("single_message_held", bus.message, 42);

        // Back-to-back until full; acks land on the timeout cycle.
        for (int i = 1; i <= 4; i++) push(i, mk(1, TIMEOUT - 1, 1'b0));
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_busy", bus.busy, 1);
        push(32'd5, mk(1, 0, 1'b1));
        wait_idle("b2b");
        chk("b2b_sent_count", bus.sent_count, tot_sent);

        // Retry then success on the third send.
        push(32'd7, mk(3, $urandom_range(0, TIMEOUT - 1), 1'b0));
        wait_idle("retry");
        chk("retry_sent_count", bus.sent_count, tot_sent);
        chk("retry_drop_count", bus.drop_count, 0);

        // Never acknowledged: dropped after MAX_RETRY retransmissions.
        push(32'd9, mk(0, 0, 1'b0));
        wait_idle("drop");
        chk("drop_drop_count", bus.drop_count, 1);
        chk("drop_fifo_empty", bus.in_ready, 1);
        chk("drop_err_single", bus.drop_err, 0);

        // ack on SEND cycles is ignored; ack on the timeout cycle counts.
        push(32'd21, mk(1, TIMEOUT - 1, 1'b1));
        push(32'd22, mk(2, 0, 1'b1));
        wait_idle("boundary");
        chk("boundary_sent_count", bus.sent_count, tot_sent);

        // Randomised traffic with stray acks while idle.
        idle_ack_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push($urandom, mk($urandom_range(0, MAX_RETRY + 1),
                              ($urandom_range(0, 3) == 0) ? TIMEOUT - 1
                                                          : $urandom_range(0, TIMEOUT - 1),
                              1'($urandom_range(0, 1))));
        end
        wait_idle("random");
        chk("random_sent_count", bus.sent_count, tot_sent);
        chk("random_drop_count", bus.drop_count, tot_drop);
        idle_ack_en = 1'b0;

        // Reset while waiting for ack with three words queued.
        push(32'd31, mk(0, 0, 1'b0));
        push(32'd32, mk(0, 0, 1'b0));
        push(32'd33, mk(0, 0, 1'b0));
        g = 0;
        while (!bus.send && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("midreset_send_seen", g < 50, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        plan_q.delete();
        @(negedge clk);
        chk_reset_vals("midreset");
        reset    = 1'b0;
        tot_sent = 0;
        tot_drop = 0;
        @(negedge clk);
        chk("postreset_send", bus.send, 0);
        chk("postreset_drop_err", bus.drop_err, 0);
        push(32'd11, mk(1, $urandom_range(0, TIMEOUT - 1), 1'b0));
        wait_idle("postreset");
        chk("postreset_sent_count", bus.sent_count, 1);
        chk("postreset_drop_count", bus.drop_count, 0);
        chk("postreset_message", bus.message, 11);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
